demux_1_to_n_stream: RTL and testbench

- Parametrised, registered successor to the 1-to-4 combinational demultiplexer.
- Routes a valid/ready input stream to one of NCH output channels. Each channel has a one-entry output register.
- Two routing modes: addressed (explicit select) and round-robin (internal pointer).
- Sits between a single producer and NCH independent consumers in the datapath test designs.

---
 rtl/demux_1_to_n_stream.sv | 92 +++++++++
 tb/tb_demux_1_to_n_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_n_stream.sv
// Registered 1-to-NCH stream demultiplexer with addressed and round-robin routing.
// Each channel owns a one-entry output register; bad addressed selects are dropped and counted.
module demux_1_to_n_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned ERRW  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [SELW-1:0]      rr_ptr,
  output logic [ERRW-1:0]      err_count
);

  logic [NCH-1:0]       out_valid_q, out_valid_d;
  logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ERRW-1:0]      err_q, err_d;

  logic [SELW-1:0] tgt;
  logic            tgt_ok;
  logic            accept;
  logic [NCH-1:0]  free;
  logic [NCH-1:0]  load;

  always_comb begin
    tgt      = mode ? rr_ptr_q : sel;
    free     = ~out_valid_q | out_ready;
    tgt_ok   = 1'b0;
    // An out-of-range target has no register behind it, so it always accepts.
    in_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (tgt == SELW'(i)) begin
        tgt_ok   = 1'b1;
        in_ready = free[i];
      end
    end
    accept = in_valid & in_ready;

    load = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      load[i] = accept & (tgt == SELW'(i));
    end

    // A load wins over a drain, giving back-to-back throughput per channel.
    out_valid_d = load | (out_valid_q & ~out_ready);
    out_data_d  = out_data_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (load[i]) begin
        out_data_d[i*WIDTH +: WIDTH] = in_data;
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (accept && mode) begin
      rr_ptr_d = (rr_ptr_q == SELW'(NCH - 1)) ? '0 : rr_ptr_q + SELW'(1);
    end

    err_d = err_q;
    if (accept && !mode && !tgt_ok && (err_q != '1)) begin
      err_d = err_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rr_ptr    = rr_ptr_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Scoreboard bench: a 4-channel and a 3-channel instance share one randomized input stream;
// accepted beats are queued per channel and popped when the consumer handshake happens.
module tb_demux_1_to_n_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] sel = '0;
  logic       mode = 1'b0;
  logic [3:0] out_ready = '0;

  logic        ir4, ir3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [1:0]  rp4, rp3;
  logic [7:0]  ec4, ec3;

  always #5 clk = ~clk;

  demux_1_to_n_stream #(.WIDTH(8), .NCH(4), .SELW(2), .ERRW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .sel(sel), .mode(mode), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
    .rr_ptr(rp4), .err_count(ec4)
  );

  demux_1_to_n_stream #(.WIDTH(8), .NCH(3), .SELW(2), .ERRW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .sel(sel), .mode(mode), .out_valid(ov3), .out_ready(out_ready[2:0]), .out_data(od3),
    .rr_ptr(rp3), .err_count(ec3)
  );

  int total = 0;
  int bad = 0;

  // Reference state: per-instance, per-channel expected contents, RR target, drop count.
  logic [7:0] exp_q [2][4][$];
  int         rr_m [2];
  int         err_m [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int nch_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) exp_q[k][c].delete();
      rr_m[k]  = 0;
      err_m[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: on each consumer handshake pop the oldest expected beat and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < nch_of(k); c++) begin
          logic       v;
          logic [7:0] d;
          v = (k == 0) ? ov4[c] : ov3[c];
          d = (k == 0) ? od4[c*8 +: 8] : od3[c*8 +: 8];
          chk("out_valid", k, {31'd0, v}, {31'd0, exp_q[k][c].size() != 0});
          if (v && out_ready[c]) begin
            if (exp_q[k][c].size() == 0) chk("unexpected_beat", k, {24'd0, d}, 32'hffff_ffff);
            else chk("out_data", k, {24'd0, d}, {24'd0, exp_q[k][c].pop_front()});
          end
        end
      end
    end
  end

  // Issue side: decide acceptance from routing rules and queue the expected beat.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        int   n, tgt;
        logic er;
        n   = nch_of(k);
        tgt = mode ? rr_m[k] : int'(sel);
        chk("rr_ptr", k, {30'd0, (k == 0) ? rp4 : rp3}, rr_m[k]);
        chk("err_count", k, {24'd0, (k == 0) ? ec4 : ec3}, err_m[k]);
        // A channel whose beat drains this cycle was already popped, so empty == free.
        er = (tgt < n) ? ((exp_q[k][tgt].size() == 0) || out_ready[tgt]) : 1'b1;
        chk("in_ready", k, {31'd0, (k == 0) ? ir4 : ir3}, {31'd0, er});
        if (in_valid && er) begin
          if (tgt < n) exp_q[k][tgt].push_back(in_data);
          else if (err_m[k] < 255) err_m[k]++;
          if (mode) rr_m[k] = (rr_m[k] + 1) % n;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_out_valid", 0, {28'd0, ov4}, 0);
    chk("rst_out_valid", 1, {29'd0, ov3}, 0);
    chk("rst_out_data", 0, od4, 0);
    chk("rst_out_data", 1, {8'd0, od3}, 0);
    chk("rst_rr_ptr", 0, {30'd0, rp4}, 0);
    chk("rst_rr_ptr", 1, {30'd0, rp3}, 0);
    chk("rst_err_count", 0, {24'd0, ec4}, 0);
    chk("rst_err_count", 1, {24'd0, ec3}, 0);
    chk("rst_in_ready", 0, {31'd0, ir4}, 1);
    chk("rst_in_ready", 1, {31'd0, ir3}, 1);
  endtask

  task automatic rand_traffic(input int cycles, input int hold_mode);
    for (int i = 0; i < cycles; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      sel       = 2'($urandom);
      out_ready = 4'($urandom);
      if (!hold_mode && $urandom_range(0, 7) == 0) mode = ~mode;
      tick();
    end
  endtask

  initial begin
    model_clear();
    // Reset with traffic present.
    in_valid  = 1'b1;
    in_data   = 8'h5a;
    sel       = 2'd1;
    out_ready = 4'hf;
    #2;
    check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;

    // Addressed: load ch2, stall on a full ch2, then refill in the draining cycle.
    mode = 1'b0; out_ready = 4'h0;
    in_valid = 1'b1; in_data = 8'ha1; sel = 2'd2;
    tick();
    in_data = 8'ha2;
    tick();
    out_ready = 4'h4;
    tick();
    in_valid = 1'b0; out_ready = 4'hf;
    tick();
    tick();

    // Round-robin burst of six beats, all consumers ready.
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rr_after_burst", 0, {30'd0, rp4}, 2);

    rand_traffic(1500, 0);

    // Bad select flood: drain, then 300 beats to sel=3.
    in_valid = 1'b0; out_ready = 4'hf;
    tick(); tick();
    mode = 1'b0; sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("err_saturated", 1, {24'd0, ec3}, 255);

    // Asynchronous reset in the middle of traffic.
    rand_traffic(40, 0);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    tick();
    tick();
    rst_n = 1'b1;

    rand_traffic(800, 0);
    in_valid = 1'b0; out_ready = 4'hf;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
